// File: rtl/debounce_pkg.sv
// Shared types, default parameters and width helpers for the button debouncer array.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        DONE
    } hold_state_t;

    localparam int unsigned DEF_NUM_CH          = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_HOLD_CYCLES     = 25000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;
    localparam bit          DEF_ACTIVE_LOW      = 1'b0;

    // Bits needed to hold the value n; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_array_if.sv
// Raw button inputs and debounced level/pulse outputs for all channels.
interface button_debouncer_array_if #(
    parameter int unsigned NUM_CH = debounce_pkg::DEF_NUM_CH
);
    logic [NUM_CH-1:0] btn_raw;
    logic [NUM_CH-1:0] btn_level;
    logic [NUM_CH-1:0] press_pulse;
    logic [NUM_CH-1:0] release_pulse;
    logic [NUM_CH-1:0] long_pulse;
    logic [NUM_CH-1:0] repeat_pulse;

    modport master (
        output btn_raw,
        input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/debounce_channel.sv
// One channel: two-flop synchroniser, stability-window debounce, edge pulses
// and the long-press / auto-repeat hold FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_accept;

    assign w_s      = r_sync2 ^ ACTIVE_LOW;
    assign w_accept = (w_s != r_level) && (r_cnt == DB_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= ACTIVE_LOW;
            r_sync2   <= ACTIVE_LOW;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= w_accept && w_s;
            r_release <= w_accept && !w_s;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int HOLD_W = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
        localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES);

        hold_state_t       r_state;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic              r_long;
        logic              r_repeat;

        // The FSM moves on the same edge that accepts the level change, so hold_cnt
        // already reads 1 in the press_pulse cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
                r_long     <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_long   <= 1'b0;
                r_repeat <= 1'b0;
                if (w_accept && !w_s) begin
                    r_state    <= IDLE;
                    r_hold_cnt <= '0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_accept && w_s) begin
                                r_state    <= HOLD;
                                r_hold_cnt <= HOLD_W'(1);
                            end
                        end
                        HOLD: begin
                            if (r_hold_cnt == HOLD_LAST) begin
                                r_long     <= 1'b1;
                                r_hold_cnt <= HOLD_W'(1);
                                r_state    <= (REPEAT_CYCLES > 0) ? REPEAT : DONE;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (r_hold_cnt == REP_LAST) begin
                                r_repeat   <= 1'b1;
                                r_hold_cnt <= HOLD_W'(1);
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        assign o_long   = r_long;
        assign o_repeat = r_repeat;
    end else begin : g_no_hold
        assign o_long   = 1'b0;
        assign o_repeat = 1'b0;
    end

endmodule

// File: rtl/button_debouncer_array.sv
// Multi-channel button debouncer: NUM_CH independent debounce_channel instances.
module button_debouncer_array
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input logic                     clk,
    input logic                     rst,
    button_debouncer_array_if.slave bus
);
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_press;
    logic [NUM_CH-1:0] w_release;
    logic [NUM_CH-1:0] w_long;
    logic [NUM_CH-1:0] w_repeat;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (bus.btn_raw[g]),
            .o_level  (w_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g]),
            .o_long   (w_long[g]),
            .o_repeat (w_repeat[g])
        );
    end

    assign bus.btn_level     = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.long_pulse    = w_long;
    assign bus.repeat_pulse  = w_repeat;

endmodule

// File: tb/tb_button_debouncer_array.sv
// Self-checking bench: reset/press vector table, hand-written hold and reset
// sequences, and randomized stimulus against a window-based reference model.
module tb_button_debouncer_array;

    localparam int unsigned NCH  = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 3;

    logic clk = 1'b0;
    logic rst;
    logic rst_al;

    always #5 clk = ~clk;

    button_debouncer_array_if #(.NUM_CH(NCH)) bus ();
    button_debouncer_array_if #(.NUM_CH(NCH)) bus_al ();

    button_debouncer_array #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    button_debouncer_array #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst_al), .bus(bus_al)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b expected %b (level,press,release,long,repeat)",
                     name, $time, got, exp);
        end
    endtask

    // Reference model: the level flips once the last DB synchronised samples all
    // disagree with it; long/repeat follow from the cycle distance to the press.
    bit         q_raw [NCH][$];
    bit         q_s   [NCH][$];
    bit         m_level [NCH];
    int         press_at [NCH];
    int         cyc = 0;
    logic [1:0] e_level, e_press, e_rel, e_long, e_rep;

    task automatic model_step(input logic [1:0] raw, input logic r);
        bit s;
        bit flip;
        int d;
        cyc++;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r) begin
                q_raw[c].delete();
                q_raw[c].push_back(1'b0);
                q_raw[c].push_back(1'b0);
                q_s[c].delete();
                m_level[c]  = 1'b0;
                press_at[c] = -1;
            end else begin
                s = q_raw[c][0];
                void'(q_raw[c].pop_front());
                q_raw[c].push_back(raw[c]);
                q_s[c].push_back(s);
                if (q_s[c].size() > DB) void'(q_s[c].pop_front());
                flip = (q_s[c].size() == DB);
                foreach (q_s[c][k]) if (q_s[c][k] == m_level[c]) flip = 1'b0;
                if (flip) begin
                    m_level[c] = s;
                    if (s) begin
                        e_press[c]  = 1'b1;
                        press_at[c] = cyc;
                    end else begin
                        e_rel[c]    = 1'b1;
                        press_at[c] = -1;
                    end
                end
                if (m_level[c] && press_at[c] >= 0) begin
                    d = cyc - press_at[c];
                    e_long[c] = (d == int'(HOLD));
                    e_rep[c]  = (d > int'(HOLD)) && (((d - int'(HOLD)) % int'(REP)) == 0);
                end
            end
            e_level[c] = m_level[c];
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
    endfunction

    function automatic logic [9:0] outs_al();
        return {bus_al.btn_level, bus_al.press_pulse, bus_al.release_pulse,
                bus_al.long_pulse, bus_al.repeat_pulse};
    endfunction

    // Drive inputs, take one rising edge, advance the model, sample on the falling edge.
    task automatic tick(input logic [1:0] raw, input logic r, input bit use_model);
        bus.btn_raw = raw;
        rst         = r;
        @(posedge clk);
        model_step(raw, r);
        @(negedge clk);
        if (use_model) check("model", outs(), {e_level, e_press, e_rel, e_long, e_rep});
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [1:0] raw, input logic [1:0] lvl,
                           input logic [1:0] prs, input logic [1:0] rel, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{r, raw, {lvl, prs, rel, 4'b0000}});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] raw;
        logic [9:0] exp;
        int         hold_left [NCH];

        rst            = 1'b1;
        rst_al         = 1'b1;
        bus.btn_raw    = 2'b00;
        bus_al.btn_raw = 2'b11;

        // Reset, clean press (accepted 6 edges after the first sampling edge) and release.
        add_vec(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add_vec(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add_vec(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
        add_vec(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
        add_vec(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add_vec(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
        add_vec(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add_vec(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 20);
        foreach (vecs[i]) begin
            tick(vecs[i].raw, vecs[i].rst, 1'b0);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        rst_al = 1'b0;

        // Simultaneous press and release on both channels.
        for (int i = 0; i < 12; i++) begin
            tick(2'b11, 1'b0, 1'b0);
            check("sim_press", {4'b0, bus.press_pulse, bus.release_pulse, 2'b00},
                  {4'b0, (i == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00});
        end
        for (int j = 0; j < 12; j++) begin
            tick(2'b00, 1'b0, 1'b0);
            check("sim_release", {4'b0, bus.press_pulse, bus.release_pulse, 2'b00},
                  {4'b0, 2'b00, (j == 5) ? 2'b11 : 2'b00, 2'b00});
        end
        check("al_idle", outs_al(), 10'b0);

        // Long press with auto-repeat on ch0 while ch1 bounces 3 high / 1 low.
        for (int i = 0; i < 50; i++) begin
            raw[0] = (i < 36);
            raw[1] = (i < 40) ? ((i % 4) != 3) : 1'b0;
            tick(raw, 1'b0, 1'b0);
            exp = '0;
            exp[8] = (i >= 5) && (i < 41);
            exp[6] = (i == 5);
            exp[4] = (i == 41);
            exp[2] = (i == 15);
            exp[0] = (i >= 18) && (i < 41) && (((i - 18) % 3) == 0);
            check($sformatf("hold_seq%0d", i), outs(), exp);
        end

        // Active-low instance: reset five cycles after press, then a fresh press.
        for (int i = 0; i < 23; i++) begin
            bus_al.btn_raw = 2'b10;
            rst_al = (i >= 10) && (i <= 12);
            tick(2'b00, 1'b0, 1'b0);
            exp = '0;
            exp[8] = ((i >= 5) && (i < 10)) || (i >= 18);
            exp[6] = (i == 5) || (i == 18);
            check($sformatf("al_reset%0d", i), outs_al(), exp);
        end
        bus_al.btn_raw = 2'b11;
        rst_al = 1'b0;

        // Randomized runs of random length, occasional reset, checked against the model.
        for (int c = 0; c < NCH; c++) hold_left[c] = 0;
        raw = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold_left[c] == 0) begin
                    raw[c]       = $urandom_range(0, 1);
                    hold_left[c] = $urandom_range(1, 30);
                end
                hold_left[c]--;
            end
            tick(raw, ($urandom_range(0, 299) == 0), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
